// File: rtl/memoredf_lfsr_pkg.sv
// memoredf_lfsr_pkg: shared types, LFSR tap table and reset constant for the random scheduler
package memoredf_lfsr_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, OFFER} sched_state_t;

    // Reset state of the LFSR is a single one in the MSB
    localparam logic LFSR_RESET_MSB = 1'b1;

    // Maximal-length Fibonacci tap masks (bit i set = state[i] feeds the XOR)
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_B400;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0007_2000;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_random_scheduler_if.sv
// lfsr_random_scheduler_if: control inputs and grant handshake of the random scheduler
interface lfsr_random_scheduler_if #(
    parameter int STATE_WIDTH      = 16,
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int WEIGHT_WIDTH     = 8
);
    localparam int IDX_W = $clog2(NUMBER_OF_QUEUES);

    logic                                            mode;
    logic                                            seed_load;
    logic [STATE_WIDTH-1:0]                          seed_value;
    logic [NUMBER_OF_QUEUES-1:0][WEIGHT_WIDTH-1:0]   weights;
    logic [NUMBER_OF_QUEUES-1:0]                     empty;
    logic                                            grant_valid;
    logic                                            grant_ready;
    logic [IDX_W-1:0]                                grant_index;
    logic                                            grant_fallback;

    modport master (
        output mode, seed_load, seed_value, weights, empty, grant_ready,
        input  grant_valid, grant_index, grant_fallback
    );

    modport slave (
        input  mode, seed_load, seed_value, weights, empty, grant_ready,
        output grant_valid, grant_index, grant_fallback
    );

endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: free-running Fibonacci LFSR with seed load and all-zero lockup guard
module lfsr_core
    import memoredf_lfsr_pkg::*;
#(
    parameter int STATE_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   seed_load,
    input  logic [STATE_WIDTH-1:0] seed_value,
    output logic [STATE_WIDTH-1:0] state
);
    localparam logic [STATE_WIDTH-1:0] TAPS        = STATE_WIDTH'(lfsr_taps(STATE_WIDTH));
    localparam logic [STATE_WIDTH-1:0] RESET_STATE = {LFSR_RESET_MSB, {(STATE_WIDTH-1){1'b0}}};

    logic [STATE_WIDTH-1:0] state_q, state_d;

    // Seed load beats the shift; a zero seed becomes 1 so the register can never lock up
    always_comb begin
        state_d = seed_load ? ((seed_value == '0) ? STATE_WIDTH'(1) : seed_value)
                            : {state_q[STATE_WIDTH-2:0], ^(state_q & TAPS)};
    end

    // State register, advances every cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= RESET_STATE;
        else          state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_random_scheduler.sv
// lfsr_random_scheduler: LFSR-driven queue arbiter with rotation and weighted-lottery modes
module lfsr_random_scheduler
    import memoredf_lfsr_pkg::*;
#(
    parameter int STATE_WIDTH      = 16,
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int MAX_RETRIES      = 4
) (
    input logic                    clock,
    input logic                    reset_n,
    lfsr_random_scheduler_if.slave bus
);
    localparam int SUM_WIDTH = WEIGHT_WIDTH + $clog2(NUMBER_OF_QUEUES);
    localparam int IDX_W     = $clog2(NUMBER_OF_QUEUES);
    localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] LAST_RETRY = RETRY_W'(MAX_RETRIES - 1);

    logic [STATE_WIDTH-1:0] lfsr_state;
    logic [IDX_W-1:0]       rot_off, rot_pick, rot_j;
    logic [SUM_WIDTH-1:0]   total, draw;
    logic [IDX_W-1:0]       lot_pick;
    logic                   lot_hit;
    logic                   all_empty, no_weight;

    sched_state_t           fsm_q;
    logic [RETRY_W-1:0]     retry_q;
    logic                   grant_valid_q, grant_fallback_q;
    logic [IDX_W-1:0]       grant_index_q;

    lfsr_core #(.STATE_WIDTH(STATE_WIDTH)) u_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .seed_load  (bus.seed_load),
        .seed_value (bus.seed_value),
        .state      (lfsr_state)
    );

    // Rotation: first non-empty queue scanning upward from state % N; scanning high k to low lets the smallest offset win
    always_comb begin
        rot_off  = IDX_W'(lfsr_state % STATE_WIDTH'(NUMBER_OF_QUEUES));
        rot_pick = '0;
        rot_j    = '0;
        for (int k = NUMBER_OF_QUEUES - 1; k >= 0; k--) begin
            rot_j = IDX_W'((int'(rot_off) + k) % NUMBER_OF_QUEUES);
            if (!bus.empty[rot_j]) rot_pick = rot_j;
        end
    end

    // Lottery: running weight sum over non-empty queues; first crossing above the draw is the pick, and any crossing means accept
    always_comb begin
        draw     = lfsr_state[SUM_WIDTH-1:0];
        total    = '0;
        lot_pick = '0;
        lot_hit  = 1'b0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            total = total + (bus.empty[i] ? SUM_WIDTH'(0) : SUM_WIDTH'(bus.weights[i]));
            if (!lot_hit && draw < total) begin
                lot_pick = IDX_W'(i);
                lot_hit  = 1'b1;
            end
        end
    end

    assign all_empty = &bus.empty;
    assign no_weight = (total == '0);

    // Scheduler FSM with registered grant outputs held through OFFER
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q            <= IDLE;
            retry_q          <= '0;
            grant_valid_q    <= 1'b0;
            grant_index_q    <= '0;
            grant_fallback_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (!all_empty) begin
                        if (bus.mode && !no_weight) begin
                            retry_q <= '0;
                            fsm_q   <= DRAW;
                        end else begin
                            grant_index_q    <= rot_pick;
                            grant_fallback_q <= bus.mode;
                            grant_valid_q    <= 1'b1;
                            fsm_q            <= OFFER;
                        end
                    end
                end
                DRAW: begin
                    if (all_empty) begin
                        fsm_q <= IDLE;
                    end else if (lot_hit) begin
                        grant_index_q    <= lot_pick;
                        grant_fallback_q <= 1'b0;
                        grant_valid_q    <= 1'b1;
                        fsm_q            <= OFFER;
                    end else if (no_weight || retry_q == LAST_RETRY) begin
                        grant_index_q    <= rot_pick;
                        grant_fallback_q <= 1'b1;
                        grant_valid_q    <= 1'b1;
                        fsm_q            <= OFFER;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                OFFER: begin
                    if (bus.grant_ready) begin
                        grant_valid_q <= 1'b0;
                        fsm_q         <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign bus.grant_valid    = grant_valid_q;
    assign bus.grant_index    = grant_index_q;
    assign bus.grant_fallback = grant_fallback_q;

endmodule

// File: tb/tb_lfsr_random_scheduler.sv
// tb_lfsr_random_scheduler: directed self-checking bench for the LFSR random scheduler
module tb_lfsr_random_scheduler;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    int   hist [4];
    int   lot  [4];
    int   fb_cnt, lat_max, lat_min, idx, lat, lot_total;
    logic fb;

    lfsr_random_scheduler_if #(.STATE_WIDTH(16), .NUMBER_OF_QUEUES(4), .WEIGHT_WIDTH(8)) bus ();

    lfsr_random_scheduler #(
        .STATE_WIDTH(16), .NUMBER_OF_QUEUES(4), .WEIGHT_WIDTH(8), .MAX_RETRIES(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        bus.weights[0] = 8'(w0);
        bus.weights[1] = 8'(w1);
        bus.weights[2] = 8'(w2);
        bus.weights[3] = 8'(w3);
    endtask

    // Wait (bounded) for a grant, record it, then let grant_ready=1 consume it
    task automatic take_grant(output int g_idx, output logic g_fb, output int g_lat);
        g_lat = 0;
        while (bus.grant_valid !== 1'b1 && g_lat < 16) begin
            step();
            g_lat++;
        end
        if (bus.grant_valid !== 1'b1) begin
            check("grant_timeout", 32'(bus.grant_valid), 32'd1);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "grant wait bound expired");
        end
        g_idx = int'(bus.grant_index);
        g_fb  = bus.grant_fallback;
        step();
    endtask

    initial begin
        bus.mode       = 1'b0;
        bus.seed_load  = 1'b0;
        bus.seed_value = '0;
        bus.weights    = '0;
        bus.empty      = '1;
        bus.grant_ready = 1'b0;

        // Reset and first LFSR advances
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 32'(dut.lfsr_state), 32'h8000);
        check("reset_valid", 32'(bus.grant_valid), 32'd0);
        check("reset_index", 32'(bus.grant_index), 32'd0);
        check("reset_fallback", 32'(bus.grant_fallback), 32'd0);
        reset_n = 1'b1;
        step();
        check("adv1_state", 32'(dut.lfsr_state), 32'h0001);
        check("adv1_valid", 32'(bus.grant_valid), 32'd0);
        step();
        check("adv2_state", 32'(dut.lfsr_state), 32'h0002);
        check("adv2_valid", 32'(bus.grant_valid), 32'd0);

        // Rotation with only queue 2 non-empty: always index 2, one cycle latency, two cycles per grant
        bus.grant_ready = 1'b1;
        bus.empty       = 4'b1011;
        for (int g = 0; g < 3; g++) begin
            step();
            check("rot_single_valid", 32'(bus.grant_valid), 32'd1);
            check("rot_single_index", 32'(bus.grant_index), 32'd2);
            check("rot_single_fallback", 32'(bus.grant_fallback), 32'd0);
            step();
            check("rot_single_release", 32'(bus.grant_valid), 32'd0);
        end

        // Rotation distribution over 4096 grants, all queues busy
        bus.empty = 4'b0000;
        fb_cnt = 0;
        lat_max = 0;
        for (int q = 0; q < 4; q++) hist[q] = 0;
        for (int g = 0; g < 4096; g++) begin
            take_grant(idx, fb, lat);
            hist[idx]++;
            fb_cnt += int'(fb);
            if (lat > lat_max) lat_max = lat;
        end
        check_range("rot_hist_q0", hist[0], 922, 1126);
        check_range("rot_hist_q1", hist[1], 922, 1126);
        check_range("rot_hist_q2", hist[2], 922, 1126);
        check_range("rot_hist_q3", hist[3], 922, 1126);
        check("rot_fallback_count", 32'(fb_cnt), 32'd0);
        check("rot_latency_max", 32'(lat_max), 32'd1);

        // Lottery with weights {0,0,3,1}: accepted draws go only to q2/q3, q2 favoured
        bus.mode = 1'b1;
        set_weights(0, 0, 3, 1);
        fb_cnt = 0; lat_max = 0; lat_min = 99;
        for (int q = 0; q < 4; q++) lot[q] = 0;
        for (int g = 0; g < 4000; g++) begin
            take_grant(idx, fb, lat);
            if (!fb) lot[idx]++;
            fb_cnt += int'(fb);
            if (lat > lat_max) lat_max = lat;
            if (lat < lat_min) lat_min = lat;
        end
        check("lot_q0q1_never", 32'(lot[0] + lot[1]), 32'd0);
        check_range("lot_q3_seen", lot[3], 1, 4000);
        check_range("lot_q2_over_q3", lot[2], lot[3] + 1, 4000);
        check_range("lot_fallback_seen", fb_cnt, 1, 4000);
        check_range("lot_latency_max", lat_max, 2, 5);
        check_range("lot_latency_min", lat_min, 2, 5);

        // Same 3:1 ratio scaled up so most draws are accepted and the share is measurable
        set_weights(0, 0, 192, 64);
        lat_max = 0; lat_min = 99;
        for (int q = 0; q < 4; q++) lot[q] = 0;
        for (int g = 0; g < 2000; g++) begin
            take_grant(idx, fb, lat);
            if (!fb) lot[idx]++;
            if (lat > lat_max) lat_max = lat;
            if (lat < lat_min) lat_min = lat;
        end
        lot_total = lot[0] + lot[1] + lot[2] + lot[3];
        check("lot2_q0q1_never", 32'(lot[0] + lot[1]), 32'd0);
        check_range("lot2_q2_percent", (lot_total == 0) ? 0 : lot[2] * 100 / lot_total, 70, 80);
        check_range("lot2_latency_max", lat_max, 2, 5);
        check_range("lot2_latency_min", lat_min, 2, 5);

        // Backpressure: grant held while empty and weights wiggle
        bus.empty = '1;
        bus.mode = 1'b0;
        bus.grant_ready = 1'b0;
        step();
        check("bp_idle_valid", 32'(bus.grant_valid), 32'd0);
        bus.empty = 4'b1011;
        step();
        check("bp_offer_valid", 32'(bus.grant_valid), 32'd1);
        check("bp_offer_index", 32'(bus.grant_index), 32'd2);
        for (int c = 0; c < 10; c++) begin
            bus.empty = (c % 2 == 0) ? 4'b1110 : 4'b0111;
            set_weights(c, 10 - c, 0, 255);
            bus.mode = c[0];
            step();
            check("bp_hold_valid", 32'(bus.grant_valid), 32'd1);
            check("bp_hold_index", 32'(bus.grant_index), 32'd2);
            check("bp_hold_fallback", 32'(bus.grant_fallback), 32'd0);
        end
        bus.grant_ready = 1'b1;
        bus.empty = '1;
        step();
        check("bp_release_valid", 32'(bus.grant_valid), 32'd0);

        // Weights {1,0,0,0}, seed 0xFFFF: draws 0x3FF,0x3FE,0x3FC,0x3F8 all reject,
        // fallback on the 5th edge picks 0xFFF8 % 4 = 0
        bus.mode = 1'b1;
        set_weights(1, 0, 0, 0);
        bus.seed_load = 1'b1;
        bus.seed_value = 16'hFFFF;
        bus.empty = 4'b0000;
        step();
        bus.seed_load = 1'b0;
        check("rej_seed_state", 32'(dut.lfsr_state), 32'hFFFF);
        check("rej_draw_valid", 32'(bus.grant_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rej_retry_valid", 32'(bus.grant_valid), 32'd0);
        end
        check("rej_state_before_fallback", 32'(dut.lfsr_state), 32'hFFF8);
        step();
        check("rej_fallback_valid", 32'(bus.grant_valid), 32'd1);
        check("rej_fallback_flag", 32'(bus.grant_fallback), 32'd1);
        check("rej_fallback_index", 32'(bus.grant_index), 32'd0);
        bus.empty = '1;
        step();
        check("rej_release_valid", 32'(bus.grant_valid), 32'd0);

        // All weights zero: fallback straight from IDLE, 0xFFFF % 4 = 3
        set_weights(0, 0, 0, 0);
        bus.seed_load = 1'b1;
        bus.seed_value = 16'hFFFF;
        step();
        bus.seed_load = 1'b0;
        bus.empty = 4'b0000;
        step();
        check("zero_w_valid", 32'(bus.grant_valid), 32'd1);
        check("zero_w_fallback", 32'(bus.grant_fallback), 32'd1);
        check("zero_w_index", 32'(bus.grant_index), 32'd3);
        bus.empty = '1;
        step();
        check("zero_w_release", 32'(bus.grant_valid), 32'd0);

        // Seed handling: zero seed becomes 1; 0x1234 then shifts in tap bit 12 (set) -> 0x2469
        bus.seed_load = 1'b1;
        bus.seed_value = 16'h0000;
        step();
        check("seed_zero_guard", 32'(dut.lfsr_state), 32'h0001);
        bus.seed_value = 16'h1234;
        step();
        check("seed_load_value", 32'(dut.lfsr_state), 32'h1234);
        bus.seed_load = 1'b0;
        step();
        check("seed_next_advance", 32'(dut.lfsr_state), 32'h2469);

        // Asynchronous reset while offering
        bus.mode = 1'b0;
        bus.grant_ready = 1'b0;
        bus.empty = 4'b1011;
        step();
        check("async_pre_valid", 32'(bus.grant_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid_drop", 32'(bus.grant_valid), 32'd0);
        check("async_state", 32'(dut.lfsr_state), 32'h8000);
        #1 reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
